instr_prefetch_buffer: RTL and testbench

- Fetch-side stage sitting directly downstream of the banked instruction memory (two cascaded SPRAM banks, 15-bit word address, bank select on addr[14]).
- Generates sequential word-address read requests into the memory, captures the 1-cycle-latency read data, and queues instruction/PC pairs in a small FIFO.
- The decode stage consumes the queue through a valid/ready handshake.
- Branch/jump redirects flush the queue and discard the in-flight read.

---
 rtl/instr_prefetch_buffer.sv | 129 ++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: issues word reads to the banked instruction
// memory, captures 1-cycle-latency data and queues instruction/PC pairs for decode.
module instr_prefetch_buffer #(
  parameter int                ADDR_W   = 15,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W+1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_chip_sel,
  output logic                        mem_wren,
  output logic [7:0]                  mem_mask_wren,
  input  logic [31:0]                 mem_rdata,
  input  logic                        redirect,
  input  logic [ADDR_W+1:0]           redirect_pc,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [31:0]                 instr_out,
  output logic [ADDR_W+1:0]           instr_pc,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;
  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       instr_mem_d [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [CW:0]       occupancy;
  logic              issue;
  logic              push;
  logic              pop;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // Slots already spoken for include the read whose data arrives next edge,
  // so the FIFO can never overflow even though pops are ignored here.
  always_comb begin
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue     = !reset && !redirect && (occupancy < (CW+1)'(DEPTH));
    push      = inflight_q && !redirect;
    pop       = (count_q != '0) && instr_ready && !redirect;
  end

  always_comb begin
    fetch_ptr_d     = fetch_ptr_q;
    inflight_d      = 1'b0;
    inflight_addr_d = inflight_addr_q;
    instr_mem_d     = instr_mem_q;
    pc_mem_d        = pc_mem_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;

    if (redirect) begin
      fetch_ptr_d = redirect_pc[ADDR_W+1:2];
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
    end else begin
      if (issue) begin
        inflight_d      = 1'b1;
        inflight_addr_d = fetch_ptr_q;
        fetch_ptr_d     = fetch_ptr_q + ADDR_W'(1);
      end
      if (push) begin
        instr_mem_d[wr_ptr_q] = mem_rdata;
        pc_mem_d[wr_ptr_q]    = inflight_addr_q;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_ptr_q     <= RESET_PC[ADDR_W+1:2];
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      instr_mem_q     <= '{default: '0};
      pc_mem_q        <= '{default: '0};
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      fetch_ptr_q     <= fetch_ptr_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      instr_mem_q     <= instr_mem_d;
      pc_mem_q        <= pc_mem_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
    end
  end

  assign mem_addr      = fetch_ptr_q;
  assign mem_chip_sel  = issue;
  assign mem_wren      = 1'b0;
  assign mem_mask_wren = 8'h00;
  assign instr_valid   = (count_q != '0);
  assign instr_out     = instr_mem_q[rd_ptr_q];
  assign instr_pc      = {pc_mem_q[rd_ptr_q], 2'b00};
  assign level         = count_q;

`ifndef SYNTHESIS
  // A push into a full queue means the issue throttle is broken.
  assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count_q == CW'(DEPTH))));
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: queue-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_instr_prefetch_buffer;

  localparam int ADDR_W = 15;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_chip_sel;
  logic              mem_wren;
  logic [7:0]        mem_mask_wren;
  logic [31:0]       mem_rdata;
  logic              redirect;
  logic [ADDR_W+1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr_out;
  logic [ADDR_W+1:0] instr_pc;
  logic [2:0]        level;

  int nvec;
  int nmis;

  int     mq[$];
  int     m_inflight;
  int     m_inflight_addr;
  int     m_fetch;
  bit     m_issue;
  int     issued[$];
  entry_t delivered[$];

  instr_prefetch_buffer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_addr     (mem_addr),
    .mem_chip_sel (mem_chip_sel),
    .mem_wren     (mem_wren),
    .mem_mask_wren(mem_mask_wren),
    .mem_rdata    (mem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc),
    .level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory stand-in: word at address a holds a + 0x100.
  initial mem_rdata = 32'h0;
  always @(posedge clk) begin
    if (mem_chip_sel) mem_rdata <= 32'(mem_addr) + 32'h100;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_issued(input int idx, input int exp);
    if (idx >= issued.size()) begin
      nvec++; nmis++;
      $display("[TB] FAIL issued[%0d]: got nothing, expected 0x%0h", idx, exp);
    end else begin
      check_output($sformatf("issued[%0d]", idx), 32'(issued[idx]), 32'(exp));
    end
  endtask

  task automatic check_deliv(input int idx, input int pc, input int instr);
    if (idx >= delivered.size()) begin
      nvec++; nmis++;
      $display("[TB] FAIL delivered[%0d]: got nothing, expected pc 0x%0h", idx, pc);
    end else begin
      check_output($sformatf("delivered[%0d].pc", idx), delivered[idx].pc, 32'(pc));
      check_output($sformatf("delivered[%0d].instr", idx), delivered[idx].instr, 32'(instr));
    end
  endtask

  task automatic apply_stimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of word addresses plus the single outstanding read.
  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      m_inflight = 0;
      m_fetch    = 0;
      check_output("reset.valid", 32'(instr_valid), 32'd0);
      check_output("reset.level", 32'(level), 32'd0);
      check_output("reset.chip_sel", 32'(mem_chip_sel), 32'd0);
    end else begin
      m_issue = !redirect && (mq.size() + m_inflight < DEPTH);
      check_output("model.chip_sel", 32'(mem_chip_sel), 32'(m_issue));
      if (m_issue) check_output("model.mem_addr", 32'(mem_addr), 32'(m_fetch));
      check_output("model.level", 32'(level), 32'(mq.size()));
      check_output("model.valid", 32'(instr_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        check_output("model.instr_pc", 32'(instr_pc), 32'(mq[0] * 4));
        check_output("model.instr_out", instr_out, 32'(mq[0]) + 32'h100);
      end
      if (mem_chip_sel) issued.push_back(int'(mem_addr));
      if (!redirect && instr_valid && instr_ready)
        delivered.push_back('{instr: instr_out, pc: 32'(instr_pc)});
      if (redirect) begin
        mq.delete();
        m_inflight = 0;
        m_fetch    = int'(redirect_pc) / 4;
      end else begin
        if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
        if (m_inflight != 0) mq.push_back(m_inflight_addr);
        if (m_issue) begin
          m_inflight      = 1;
          m_inflight_addr = m_fetch;
          m_fetch         = (m_fetch + 1) % (1 << ADDR_W);
        end else begin
          m_inflight = 0;
        end
      end
    end
  end

  initial begin
    int polls;
    nvec = 0;
    nmis = 0;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    #2;
    apply_stimulus(3);
    check_output("reset.wren", 32'(mem_wren), 32'd0);
    check_output("reset.mask_wren", 32'(mem_mask_wren), 32'd0);

    // Straight-line fetch from reset with decode always ready.
    issued.delete(); delivered.delete();
    reset = 1'b0;
    #1;
    check_output("release.chip_sel", 32'(mem_chip_sel), 32'd1);
    check_output("release.mem_addr", 32'(mem_addr), 32'd0);
    apply_stimulus(1);
    check_output("edge1.valid", 32'(instr_valid), 32'd0);
    apply_stimulus(1);
    check_output("edge2.valid", 32'(instr_valid), 32'd1);
    check_output("edge2.pc", 32'(instr_pc), 32'h0);
    check_output("edge2.instr", instr_out, 32'h100);
    apply_stimulus(4);
    check_issued(0, 0); check_issued(1, 1); check_issued(2, 2);
    check_deliv(0, 'h0, 'h100); check_deliv(1, 'h4, 'h101); check_deliv(2, 'h8, 'h102);

    // Decode stalled: four reads fill the queue, then fetch stops.
    reset = 1'b1;
    apply_stimulus(2);
    issued.delete(); delivered.delete();
    instr_ready = 1'b0;
    reset = 1'b0;
    apply_stimulus(10);
    check_output("stall.issued_count", 32'(issued.size()), 32'd4);
    check_issued(3, 3);
    check_output("stall.level", 32'(level), 32'd4);
    check_output("stall.chip_sel", 32'(mem_chip_sel), 32'd0);
    instr_ready = 1'b1;
    apply_stimulus(10);
    check_deliv(0, 'h0, 'h100); check_deliv(3, 'hC, 'h103); check_deliv(4, 'h10, 'h104);
    check_deliv(5, 'h14, 'h105);
    check_issued(4, 4); check_issued(5, 5);

    // Redirect with a read in flight and a pop handshake in the same cycle.
    check_output("preredir.valid", 32'(instr_valid), 32'd1);
    issued.delete(); delivered.delete();
    redirect = 1'b1;
    redirect_pc = 17'h1_0008;
    #1;
    check_output("redir.chip_sel", 32'(mem_chip_sel), 32'd0);
    apply_stimulus(1);
    redirect = 1'b0;
    #1;
    check_output("postredir.level", 32'(level), 32'd0);
    check_output("postredir.valid", 32'(instr_valid), 32'd0);
    check_output("postredir.mem_addr", 32'(mem_addr), 32'h4002);
    check_output("postredir.chip_sel", 32'(mem_chip_sel), 32'd1);
    apply_stimulus(1);
    check_output("redir_edge1.valid", 32'(instr_valid), 32'd0);
    apply_stimulus(1);
    check_output("redir_edge2.valid", 32'(instr_valid), 32'd1);
    check_output("redir_edge2.pc", 32'(instr_pc), 32'h1_0008);
    apply_stimulus(3);
    check_deliv(0, 'h1_0008, 'h4102); check_deliv(1, 'h1_000C, 'h4103);

    // Last word of bank 1 wraps to address zero.
    issued.delete(); delivered.delete();
    redirect = 1'b1;
    redirect_pc = 17'h1_FFFC;
    apply_stimulus(1);
    redirect = 1'b0;
    apply_stimulus(6);
    check_issued(0, 'h7FFF); check_issued(1, 'h0);
    check_deliv(0, 'h1_FFFC, 'h80FF); check_deliv(1, 'h0, 'h100);

    // Asynchronous reset mid-burst once three entries are queued.
    reset = 1'b1;
    apply_stimulus(2);
    instr_ready = 1'b0;
    reset = 1'b0;
    polls = 0;
    while (level != 3'd3 && polls < 20) begin
      apply_stimulus(1);
      polls++;
    end
    check_output("burst.level", 32'(level), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check_output("async.valid", 32'(instr_valid), 32'd0);
    check_output("async.level", 32'(level), 32'd0);
    check_output("async.chip_sel", 32'(mem_chip_sel), 32'd0);
    apply_stimulus(2);
    issued.delete(); delivered.delete();
    instr_ready = 1'b1;
    reset = 1'b0;
    apply_stimulus(4);
    check_issued(0, 0); check_issued(1, 1);
    check_deliv(0, 'h0, 'h100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
